// File: rtl/reg_dump_ctrl.sv
// Sequencing read initiator: walks a register-file address range on a spare read port
// and streams {address, data} beats on a valid/ready port with a last marker and XOR checksum.
module reg_dump_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] xor_sum
);

    // state   | meaning
    // S_IDLE  | waiting for start; checksum of previous dump held
    // S_RUN   | reading cur and loading beats into the output register
    // S_DRAIN | final beat loaded, waiting for its handshake
    // S_DONE  | one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_busy;
    logic              w_done;

    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_end;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic [DATA_W-1:0] r_xor;

    logic              w_accept;
    logic              w_load;
    logic              w_at_end;
    logic              w_hs;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_at_end = (r_cur == r_end);
    assign w_hs     = r_out_valid && out_ready;
    // Reload whenever the output register is empty or being emptied this edge.
    assign w_load   = (r_state == S_RUN) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = (first_addr <= last_addr) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_load && w_at_end) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= '0;
            r_end       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_xor       <= '0;
        end else if (w_accept) begin
            r_cur <= first_addr;
            r_end <= last_addr;
            r_xor <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_cur;
            r_out_data  <= rf_rdata;
            r_out_last  <= w_at_end;
            r_xor       <= r_xor ^ rf_rdata;
            // cur parks on end so it can never wrap past the top register.
            if (!w_at_end) begin
                r_cur <= r_cur + ADDR_W'(1);
            end
        end else if ((r_state == S_DRAIN) && w_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign rf_raddr  = r_cur;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign xor_sum   = r_xor;

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Sequencing read initiator for the 32×32 register file: on a start pulse it walks a programmed address range, drives the register file read port, and streams each `{address, data}` pair out on a valid/ready interface with a last marker and a running XOR checksum. It sits beside the register file on a spare read port and feeds debug/trace logic, the scan-out path or a test bench scoreboard, without disturbing the pipeline's own reads and writes.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`
- `first_addr`  in  ADDR_W  first register index, sampled with `start`
- `last_addr`  in  ADDR_W  last register index (inclusive), sampled with `start`
- `busy`  out  1  high while state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of dump
- `rf_raddr`  out  ADDR_W  register file read address (combinational read port)
- `rf_rdata`  in  DATA_W  register file read data, same-cycle response to `rf_raddr`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_addr`  out  ADDR_W  register index of current beat
- `out_data`  out  DATA_W  register contents of current beat
- `out_last`  out  1  current beat is the final beat of the dump
- `xor_sum`  out  DATA_W  XOR of all captured `out_data` words of current/last dump

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, latch `first_addr`→`cur`, `last_addr`→`end`, clear `xor_sum`. If `first_addr` ≤ `last_addr` → RUN; else → DONE (empty dump, zero beats).
- `rf_raddr` = `cur` at all times (registered counter; 0 in reset/IDLE after reset).
- Load condition: state RUN and (`!out_valid` or `out_ready`).
- On load: `out_data`←`rf_rdata`, `out_addr`←`cur`, `out_last`←(`cur`==`end`), `out_valid`←1, `xor_sum`←`xor_sum`^`rf_rdata`. If `cur`==`end` → DRAIN, else `cur`←`cur`+1.
- In RUN, `out_valid && out_ready` without a load cannot happen (load condition covers it); handshake and reload occur on the same edge.
- DRAIN: on `out_valid && out_ready`, `out_valid`←0 → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Output stability: while `out_valid && !out_ready`, `out_addr`, `out_data`, `out_last` hold.
- Address 0 reads as zero (register file property); beat for index 0 carries data 0.
- Data captured is the register file value at the load edge; writes landing on the same edge are not visible (read before write).
- `cur` never wraps: `end` ≤ 31, so increment stops at `end`; range 31..31 emits one beat.
- `xor_sum` holds its value after DONE until the next accepted `start`.
- `start` while `busy` has no effect; `first_addr`/`last_addr` changes mid-dump have no effect.

## Timing
- Reset (async, any time including mid-dump): state IDLE, `cur`=0, `busy`=0, `done`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `xor_sum`=0. No partial beat survives.
- `start` sampled at edge E0 → `busy` high after E0; first `out_valid` after E1 (1 idle cycle latency).
- With `out_ready` held high: one beat per cycle; N-beat dump has `out_valid` high for N consecutive cycles, `done` in the cycle after the last handshake; `busy` spans N+2 cycles.
- Empty dump (`first_addr` > `last_addr`): `done` in cycle after E0, `busy` one cycle.
- Back-to-back: new `start` accepted in the first cycle of IDLE after `done`.

## Test plan
- Preload reg[i]=0x100+i (i≥1); start 0..31, `out_ready`=1 → 32 beats, addr 0..31, data 0 then 0x101..0x11F, `out_last` only on addr 31, `done` one cycle after, `xor_sum` = XOR of those data.
- Range 3..5 with `out_ready` toggling 1,0,0,1,0,1 → exactly 3 beats (3,4,5), data held stable across stalls, no duplicates or drops, `out_last` on addr 5.
- Start with first=9, last=4 → zero beats, `done` pulse next cycle, `xor_sum`=0.
- Second `start` with first=0,last=0 while a 10..20 dump runs → ignored; 11 beats of 10..20 only.
- Assert `rst_n` low after third beat of 0..31 → all outputs 0 immediately; after release, `start` 7..7 yields single beat addr 7, `out_last`=1.
- Write reg[6]=0xDEAD on the cycle reg 6 is loaded and reg[8]=0xBEEF two cycles before reg 8 loads → beat 6 shows old value, beat 8 shows 0xBEEF.
